// File: rtl/soc_riscv_mem_arbiter.sv
// Two-master round-robin arbiter for the req/ack memory bus.
// Responses are steered back in acceptance order via an index FIFO.
module soc_riscv_mem_arbiter #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [1:0]        m_req_i,
    input  logic [2*XLEN-1:0] m_adr_i,
    input  logic [2*XLEN-1:0] m_d_i,
    input  logic [1:0]        m_we_i,
    input  logic [5:0]        m_size_i,
    output logic [1:0]        m_gnt_o,
    output logic [1:0]        m_ack_o,
    output logic [XLEN-1:0]   m_q_o,
    output logic              s_req_o,
    output logic [XLEN-1:0]   s_adr_o,
    output logic [XLEN-1:0]   s_d_o,
    output logic              s_we_o,
    output logic [2:0]        s_size_o,
    input  logic              s_gnt_i,
    input  logic              s_ack_i,
    input  logic [XLEN-1:0]   s_q_i,
    output logic              err_o
);

    localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

    logic          r_lock;
    logic          r_lock_idx;
    logic          r_last;
    logic          r_fifo [MAX_OUTSTANDING];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_err;

    logic w_sel_valid;
    logic w_sel_idx;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_head;

    // A stalled request keeps its master until accepted or withdrawn.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = 1'b0;
        if (r_lock && m_req_i[r_lock_idx]) begin
            w_sel_valid = 1'b1;
            w_sel_idx   = r_lock_idx;
        end else begin
            case (m_req_i)
                2'b01: begin w_sel_valid = 1'b1; w_sel_idx = 1'b0;    end
                2'b10: begin w_sel_valid = 1'b1; w_sel_idx = 1'b1;    end
                2'b11: begin w_sel_valid = 1'b1; w_sel_idx = ~r_last; end
                default: ;
            endcase
        end
    end

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign s_req_o  = w_sel_valid && !w_full && rst_ni;
    assign w_push   = s_req_o && s_gnt_i;
    assign w_pop    = s_ack_i && !w_empty;
    assign w_head   = r_fifo[r_rptr];

    assign m_gnt_o  = {w_push && w_sel_idx, w_push && !w_sel_idx};
    assign m_ack_o  = {w_pop && w_head, w_pop && !w_head};
    assign m_q_o    = s_q_i;

    assign s_adr_o  = w_sel_idx ? m_adr_i[2*XLEN-1:XLEN] : m_adr_i[XLEN-1:0];
    assign s_d_o    = w_sel_idx ? m_d_i[2*XLEN-1:XLEN]   : m_d_i[XLEN-1:0];
    assign s_size_o = w_sel_idx ? m_size_i[5:3]          : m_size_i[2:0];
    assign s_we_o   = w_sel_valid && rst_ni && m_we_i[w_sel_idx];
    assign err_o    = r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock     <= 1'b0;
            r_lock_idx <= 1'b0;
            r_last     <= 1'b1;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                r_fifo[i] <= 1'b0;
            end
        end else begin
            r_lock     <= s_req_o && !s_gnt_i;
            r_lock_idx <= w_sel_idx;
            if (w_push) begin
                r_fifo[r_wptr] <= w_sel_idx;
                r_wptr         <= r_wptr + 1'b1;
                r_last         <= w_sel_idx;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            if (s_ack_i && w_empty && !w_push) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_soc_riscv_mem_arbiter.sv
// Scoreboard bench for soc_riscv_mem_arbiter: a queue-based reference model
// predicts grants and acks, a negedge monitor matches them against the DUT.
module tb_soc_riscv_mem_arbiter;

    localparam int XLEN = 32;
    localparam int MAXO = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [1:0]        m_req_i = '0;
    logic [2*XLEN-1:0] m_adr_i = '0;
    logic [2*XLEN-1:0] m_d_i = '0;
    logic [1:0]        m_we_i = '0;
    logic [5:0]        m_size_i = '0;
    logic [1:0]        m_gnt_o;
    logic [1:0]        m_ack_o;
    logic [XLEN-1:0]   m_q_o;
    logic              s_req_o;
    logic [XLEN-1:0]   s_adr_o;
    logic [XLEN-1:0]   s_d_o;
    logic              s_we_o;
    logic [2:0]        s_size_o;
    logic              s_gnt_i = 1'b0;
    logic              s_ack_i = 1'b0;
    logic [XLEN-1:0]   s_q_i = '0;
    logic              err_o;

    soc_riscv_mem_arbiter #(.XLEN(XLEN), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_req_i(m_req_i), .m_adr_i(m_adr_i), .m_d_i(m_d_i), .m_we_i(m_we_i),
        .m_size_i(m_size_i), .m_gnt_o(m_gnt_o), .m_ack_o(m_ack_o), .m_q_o(m_q_o),
        .s_req_o(s_req_o), .s_adr_o(s_adr_o), .s_d_o(s_d_o), .s_we_o(s_we_o),
        .s_size_o(s_size_o), .s_gnt_i(s_gnt_i), .s_ack_i(s_ack_i), .s_q_i(s_q_i),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          cyc;
        int          idx;
        logic [31:0] q;
    } exp_t;

    exp_t gnt_q[$];
    exp_t ack_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model: outstanding masters in acceptance order plus arbitration state.
    int   order[$];
    int   m_last = 1;
    bit   m_lock = 0;
    int   m_lock_idx = 0;
    bit   m_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic predict();
        int sel;
        bit sreq, push, pop;
        if (!rst_ni) begin
            order.delete();
            m_lock = 0;
            m_last = 1;
            m_err  = 0;
        end
        sel = -1;
        if (rst_ni) begin
            if (m_lock && m_req_i[m_lock_idx]) sel = m_lock_idx;
            else if (m_req_i == 2'b01)         sel = 0;
            else if (m_req_i == 2'b10)         sel = 1;
            else if (m_req_i == 2'b11)         sel = 1 - m_last;
        end
        sreq = (sel >= 0) && (order.size() < MAXO);
        chk("s_req", 32'(s_req_o), 32'(sreq));
        chk("err", 32'(err_o), 32'(m_err));
        if (sreq) begin
            chk("s_adr", s_adr_o, sel == 1 ? m_adr_i[63:32] : m_adr_i[31:0]);
            chk("s_d", s_d_o, sel == 1 ? m_d_i[63:32] : m_d_i[31:0]);
            chk("s_we", 32'(s_we_o), 32'(m_we_i[sel]));
            chk("s_size", 32'(s_size_o), 32'(sel == 1 ? m_size_i[5:3] : m_size_i[2:0]));
        end
        push = sreq && s_gnt_i;
        pop  = s_ack_i && rst_ni && order.size() > 0;
        if (pop) begin
            ack_q.push_back('{cyc, order[0], s_q_i});
            void'(order.pop_front());
        end else if (s_ack_i && rst_ni && !push) begin
            m_err = 1;
        end
        if (push) begin
            gnt_q.push_back('{cyc, sel, 32'h0});
            order.push_back(sel);
            m_last = sel;
        end
        if (rst_ni) begin
            m_lock     = sreq && !s_gnt_i;
            m_lock_idx = sel;
        end
    endtask

    task automatic step(input logic [1:0] req, input logic gnt, input logic ack,
                        input logic rst, input logic [31:0] adr0, input logic [31:0] q);
        rst_ni   = rst;
        m_req_i  = req;
        m_adr_i  = {$urandom, adr0};
        m_d_i    = {$urandom, $urandom};
        m_we_i   = 2'($urandom);
        m_size_i = 6'($urandom);
        s_gnt_i  = gnt;
        s_ack_i  = ack;
        s_q_i    = q;
        #1;
        predict();
        @(posedge clk_i);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        step(2'b00, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
    endtask

    task automatic drain();
        for (int k = 0; k < MAXO + 2; k++) begin
            if (order.size() > 0) step(2'b00, 1'b0, 1'b1, 1'b1, $urandom, $urandom);
        end
    endtask

    // Monitor: matches every DUT grant/ack against the scoreboard entry for this cycle.
    always @(negedge clk_i) begin
        exp_t e;
        while (gnt_q.size() > 0 && gnt_q[0].cyc < cyc) begin
            n_tests++; n_fail++;
            $display("FAIL gnt_missing cyc=%0d actual=none required=master%0d", gnt_q[0].cyc, gnt_q[0].idx);
            void'(gnt_q.pop_front());
        end
        while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
            n_tests++; n_fail++;
            $display("FAIL ack_missing cyc=%0d actual=none required=master%0d", ack_q[0].cyc, ack_q[0].idx);
            void'(ack_q.pop_front());
        end
        if (m_gnt_o != 2'b00) begin
            if (gnt_q.size() == 0 || gnt_q[0].cyc != cyc) begin
                n_tests++; n_fail++;
                $display("FAIL gnt_unexpected cyc=%0d actual=%b required=00", cyc, m_gnt_o);
            end else begin
                e = gnt_q.pop_front();
                chk("gnt", 32'(m_gnt_o), 32'(1) << e.idx);
            end
        end
        if (m_ack_o != 2'b00) begin
            if (ack_q.size() == 0 || ack_q[0].cyc != cyc) begin
                n_tests++; n_fail++;
                $display("FAIL ack_unexpected cyc=%0d actual=%b required=00", cyc, m_ack_o);
            end else begin
                e = ack_q.pop_front();
                chk("ack", 32'(m_ack_o), 32'(1) << e.idx);
                chk("ack_q", m_q_o, e.q);
            end
        end
    end

    initial begin
        @(posedge clk_i);
        #1;
        do_reset();
        do_reset();

        // single master, ack two cycles after acceptance
        step(2'b01, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0);
        step(2'b00, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        step(2'b00, 1'b0, 1'b1, 1'b1, 32'h0, 32'hDEADBEEF);

        // tie after reset alternates starting with master 0, then in-order acks
        do_reset();
        repeat (4) step(2'b11, 1'b1, 1'b0, 1'b1, $urandom, $urandom);
        drain();

        // stall lock on master 1 while master 0 joins
        do_reset();
        step(2'b10, 1'b0, 1'b0, 1'b1, $urandom, $urandom);
        step(2'b11, 1'b0, 1'b0, 1'b1, $urandom, $urandom);
        step(2'b11, 1'b0, 1'b0, 1'b1, $urandom, $urandom);
        step(2'b11, 1'b1, 1'b0, 1'b1, $urandom, $urandom);
        step(2'b11, 1'b1, 1'b0, 1'b1, $urandom, $urandom);
        drain();

        // full FIFO: issue blocked until the cycle after the first ack
        do_reset();
        repeat (4) step(2'b01, 1'b1, 1'b0, 1'b1, $urandom, $urandom);
        step(2'b01, 1'b1, 1'b0, 1'b1, $urandom, $urandom);
        step(2'b01, 1'b1, 1'b1, 1'b1, $urandom, $urandom);
        step(2'b01, 1'b1, 1'b0, 1'b1, $urandom, $urandom);
        drain();

        // ack ordering m0, m1, m1, m0
        do_reset();
        step(2'b01, 1'b1, 1'b0, 1'b1, $urandom, $urandom);
        step(2'b10, 1'b1, 1'b0, 1'b1, $urandom, $urandom);
        step(2'b10, 1'b1, 1'b0, 1'b1, $urandom, $urandom);
        step(2'b01, 1'b1, 1'b0, 1'b1, $urandom, $urandom);
        drain();

        // spurious ack sets sticky error, reset clears it
        step(2'b00, 1'b0, 1'b1, 1'b1, $urandom, $urandom);
        step(2'b00, 1'b0, 1'b0, 1'b1, $urandom, $urandom);
        step(2'b00, 1'b0, 1'b0, 1'b1, $urandom, $urandom);
        do_reset();
        step(2'b00, 1'b0, 1'b0, 1'b1, $urandom, $urandom);

        // randomized traffic with occasional resets and protocol violations
        for (int i = 0; i < 800; i++) begin
            logic ack;
            if (order.size() > 0) ack = 1'($urandom % 2);
            else                  ack = ($urandom % 40) == 0;
            step(2'($urandom), ($urandom % 4) != 0, ack, ($urandom % 100) != 0,
                 $urandom, $urandom);
        end
        drain();
        repeat (2) step(2'b00, 1'b0, 1'b0, 1'b1, $urandom, $urandom);

        n_tests++;
        if (gnt_q.size() != 0 || ack_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover actual=%0d/%0d required=0/0", gnt_q.size(), ack_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
